// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiplier: ALU op codes, FSM states and widths.
package alu_mul_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ext_bit.sv
// Rebuilds the 33rd bit of an ALU add/sub from operand and result MSBs.
// MUL_SIGNED_EN: true sign of the 33-bit result; otherwise: unsigned carry-out.
module alu_ext_bit
  import alu_mul_sequencer_pkg::*;
(
  input  logic    a31,
  input  logic    b31,
  input  logic    z31,
  input  alu_op_e op,
  output logic    ext
);

  logic bx;

  // The ALU inverts b internally for SUB, so the effective b MSB flips.
  assign bx = (op == ALU_SUB) ? ~b31 : b31;

`ifdef MUL_SIGNED_EN
  logic ovf;
  assign ovf = (a31 == bx) & (z31 != a31);
  assign ext = z31 ^ ovf;
`else
  assign ext = (a31 & bx) | ((a31 ^ bx) & ~z31);
`endif

endmodule

// File: rtl/alu_mul_sequencer.sv
// 32x32->64 sequential multiplier driving an external combinational ALU, one step per cycle.
// MUL_SIGNED_EN selects radix-2 Booth (signed); default is unsigned shift-add.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  mcand,
  input  logic [XLEN-1:0]  mplier,
  output logic             busy,
  output logic             done,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_op,
  input  logic [XLEN-1:0]  alu_z
);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi, lo, mcand_r;
  logic [XLEN-1:0]   s, hi_nxt, lo_nxt;
  logic              use_z, ext, shin;
  alu_op_e           op;
`ifdef MUL_SIGNED_EN
  logic              q1;
`endif

  always_comb begin
    op    = ALU_ADD;
    use_z = 1'b0;
`ifdef MUL_SIGNED_EN
    if (state == S_RUN) begin
      case ({lo[0], q1})
        2'b10:   begin op = ALU_SUB; use_z = 1'b1; end
        2'b01:   use_z = 1'b1;
        default: use_z = 1'b0;
      endcase
    end
`else
    use_z = (state == S_RUN) & lo[0];
`endif
    s = use_z ? alu_z : hi;
`ifdef MUL_SIGNED_EN
    // No-op steps are a plain arithmetic shift of the accumulator.
    shin = use_z ? ext : hi[XLEN-1];
`else
    shin = use_z & ext;
`endif
    hi_nxt = {shin, s[XLEN-1:1]};
    lo_nxt = {s[0], lo[XLEN-1:1]};
  end

  alu_ext_bit u_ext (
    .a31 (hi[XLEN-1]),
    .b31 (mcand_r[XLEN-1]),
    .z31 (alu_z[XLEN-1]),
    .op  (op),
    .ext (ext)
  );

  assign alu_a  = hi;
  assign alu_b  = mcand_r;
  assign alu_op = op;
  assign busy   = (state == S_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(XLEN-1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      mcand_r <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
`ifdef MUL_SIGNED_EN
      q1      <= 1'b0;
`endif
    end else begin
      // Registered pulse: asserted the cycle after the DONE state.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          mcand_r <= mcand;
          lo      <= mplier;
          hi      <= '0;
          cnt     <= '0;
`ifdef MUL_SIGNED_EN
          q1      <= 1'b0;
`endif
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
`ifdef MUL_SIGNED_EN
          q1  <= lo[0];
`endif
          if (cnt == CNT_W'(XLEN-1)) product <= {hi_nxt, lo_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural combinational ALU attached.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand, mplier;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int t0     = 0;
  logic all_add;

  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_z = 32'h0;
    case (alu_op)
      3'b000: alu_z = alu_a & alu_b;
      3'b001: alu_z = alu_a | alu_b;
      3'b010: alu_z = alu_a + alu_b;
      3'b110: alu_z = alu_a - alu_b;
      3'b111: alu_z = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_z = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_mul(input logic [31:0] mc, input logic [31:0] mp);
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
  endtask

  // Waits (bounded) for done, tracking whether every RUN cycle issued ADD.
  task automatic wait_done(input string tag, input logic [63:0] exp_p);
    for (int k = 0; k < 45 && !done; k++) begin
      if (busy && alu_op !== 3'b010) all_add = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, {63'h0, done}, 64'h1);
    chk({tag, "_latency"}, 64'(cyc - t0), 64'd33);
    chk({tag, "_product"}, product, exp_p);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
    chk({tag, "_held"}, product, exp_p);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                         input logic [63:0] exp_p);
    start_mul(mc, mp);
    wait_done(tag, exp_p);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    #1;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_product", product, 64'h0);
    chk("rst_alu_a", {32'h0, alu_a}, 64'h0);
    chk("rst_alu_b", {32'h0, alu_b}, 64'h0);
    chk("rst_alu_op", {61'h0, alu_op}, 64'h2);
    #12 rst_n = 1'b1;

    // 3*5 with only ADDs issued and busy asserted while iterating
    all_add = 1'b1;
    start_mul(32'd3, 32'd5);
    chk("u3x5_busy", {63'h0, busy}, 64'h1);
    chk("u3x5_alu_b", {32'h0, alu_b}, 64'd3);
    wait_done("u3x5", 64'd15);
`ifndef MUL_SIGNED_EN
    chk("u3x5_all_add", {63'h0, all_add}, 64'h1);
    chk("u_busy_idle", {63'h0, busy}, 64'h0);
    run_mul("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_mul("umsb2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_mul("u64k", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    run_mul("uzero", 32'h0, 32'hDEAD_BEEF, 64'h0);
`else
    run_mul("s_m3x7", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul("s_min2", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
    start_mul(32'd5, 32'd1);
    chk("s_op_it0", {61'h0, alu_op}, 64'h6);
    @(posedge clk); #1;
    chk("s_op_it1", {61'h0, alu_op}, 64'h2);
    wait_done("s_5x1", 64'd5);
`endif

    // start pulsed mid-run with new operands must be ignored
    start_mul(32'd11, 32'd13);
    repeat (5) @(posedge clk);
    @(negedge clk);
    mcand = 32'd9; mplier = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_alu_b", {32'h0, alu_b}, 64'd11);
    wait_done("ign", 64'd143);

    // async reset during iteration 10
    start_mul(32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_product", product, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    run_mul("post_rst_6x7", 32'd6, 32'd7, 64'd42);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
